trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
//  Sequences machine-mode trap entry (synchronous exception or external interrupt) and MRET
//  through the single-port machine CSR register file, and arbitrates that port with the
//  pipeline's CSR instructions.
//  Sits between the core pipeline and the CSR regfile. Stalls the pipeline while a
//  sequence runs, then issues one PC redirect (trap vector or MEPC).
// PARAMETERS
//  XLEN       32      data width of CSRs and PC
//  IRQ_CAUSE  32'h8000000B  mcause value written for the machine external interrupt
// PORTS
//  clock            in   1     core clock; all state on posedge
//  rst_n            in   1     asynchronous, active-low reset
//  exc_req          in   1     synchronous exception at commit; level, sampled in IDLE only
//  exc_cause        in   32    mcause value for the exception
//  exc_tval         in   32    mtval value for the exception
//  commit_pc        in   32    PC of the committing instruction (mepc source)
//  irq_ext          in   1     machine external interrupt line (level)
//  mret_req         in   1     MRET at commit; sampled in IDLE only
//  busy             out  1     1 = sequence in progress; pipeline must stall
//  redirect_valid   out  1     single-cycle pulse: fetch from redirect_pc
//  redirect_pc      out  32    target PC
//  inst_csr_addr    in   12    pipeline CSR address
//  inst_csr_w_data  in   32    pipeline CSR write data
//  inst_csr_w_en    in   1     pipeline CSR write enable
//  inst_csr_r_data  out  32    CSR read data to pipeline (= csr_r_data)
//  csr_addr         out  12    to regfile
//  csr_w_data       out  32    to regfile
//  csr_w_en         out  1     to regfile
//  csr_r_data       in   32    from regfile (combinational read)
// BEHAVIOUR
//  Reset: state IDLE; busy=0, redirect_valid=0, redirect_pc=0; shadow_mie=0, shadow_meie=0.
//  Mid-sequence reset: abort to IDLE; CSR writes already performed remain.
//  IDLE: CSR port passes pipeline signals straight through. Snoop: a write to 0x300 updates
//   shadow_mie <= w_data[3]; a write to 0x304 updates shadow_meie <= w_data[11].
//  Acceptance in IDLE, with priority exc_req > mret_req > interrupt.
//   Interrupt taken only if irq_ext & shadow_mie & shadow_meie.
//   On acceptance, latch epc=commit_pc, cause (exc_cause or IRQ_CAUSE) and tval
//   (exc_tval, or 0 for an interrupt). Requests are not sampled while busy.
//  busy = (state != IDLE); registered. Pipeline CSR write enables are dropped while busy.
//  Trap FSM, one state per cycle:
//   W_EPC    write mepc (0x341) <= epc
//   W_CAUSE  write mcause (0x342) <= cause
//   W_TVAL   write mtval (0x343) <= tval
//   W_STATUS read-modify-write mstatus (0x300) in the same cycle:
//            MPIE[7] <= MIE[3]; MIE[3] <= 0; MPP[12:11] <= 2'b11; shadow_mie <= 0
//   R_TVEC   read mtvec (0x305):
//            mode[1:0]==1 and interrupt -> target {base[31:2],2'b00} + 4*cause[30:0]
//            otherwise                  -> target {base[31:2],2'b00}
//            register target into redirect_pc; go to IDLE
//  MRET FSM:
//   M_STATUS read-modify-write mstatus: MIE[3] <= MPIE[7]; MPIE[7] <= 1; shadow_mie tracks
//   M_EPC    read mepc; redirect_pc <= {mepc[31:2],2'b00}; go to IDLE
//  redirect_valid is registered. It is 1 for exactly the cycle after R_TVEC/M_EPC
//   (the first IDLE cycle, busy=0).
//  Latency: trap accept cycle t -> redirect_valid at t+6. MRET accept cycle t -> t+3.
//  A new request may be accepted in the same cycle redirect_valid is high.
//  When not writing during sequence states, csr_w_en=0. Unknown addresses are never driven.
// STRUCTURE
//  Shared package csr_pkg holds:
//   CSR address constants (MSTATUS..MIP)
//   mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
//   MEIE=11, IRQ cause code, and the state encoding (localparams).
//  Single module, no sub-module. The port mux and FSM are small enough to keep flat.
// TESTING
//  1 Reset, then exc_req=1, cause=2, tval=32'hDEAD, pc=0x100, mtvec=0x200
//    -> mepc=0x100, mcause=2, mtval=DEAD, mstatus.MIE=0
//    -> redirect_valid at t+6, redirect_pc=0x200.
//  2 Set mstatus=0x8, mie=0x800, mtvec=0x401, pulse irq_ext
//    -> mcause=0x8000000B, mtval=0, redirect_pc=0x42C, mstatus.MPIE=1, MIE=0.
//  3 Same as 2 but mstatus=0 -> irq ignored, busy stays 0, no redirect.
//  4 mepc=0x344, mstatus MPIE=1, mret_req
//    -> redirect_pc=0x344 at t+3, mstatus.MIE=1, MPIE=1.
//  5 exc_req, mret_req and irq all asserted in one cycle -> exception sequence only.
//    A pipeline CSR write during busy is discarded.
//  6 Deassert rst_n during W_CAUSE -> busy=0, redirect_valid=0 immediately.
//    mepc keeps its new value; a later trap completes normally.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses, mstatus/mie bit
// positions, the default interrupt cause and the sequencer state encoding.
package trap_controller_pkg;

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMisa     = 12'h301;
  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMtval    = 12'h343;
  localparam logic [11:0] CsrMip      = 12'h344;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;
  localparam int unsigned MieMeie      = 11;

  localparam logic [31:0] IrqCauseMext = 32'h8000_000B;

  localparam logic [1:0] TvecModeVectored = 2'b01;

  // Trap entry walks StWEpc..StRTvec; MRET walks StMStatus..StMEpc.
  typedef enum logic [2:0] {
    StIdle,
    StWEpc,
    StWCause,
    StWTval,
    StWStatus,
    StRTvec,
    StMStatus,
    StMEpc
  } trap_state_e;

endpackage

// File: rtl/trap_controller_if.sv
// Single-port CSR access bundle: address, write data/enable, combinational read data.
// The requester of an access is the master; the side holding the registers is the slave.
interface trap_controller_if #(
  parameter int unsigned XLEN = 32
);

  logic [11:0]     addr;
  logic [XLEN-1:0] w_data;
  logic            w_en;
  logic [XLEN-1:0] r_data;

  modport master (
    output addr,
    output w_data,
    output w_en,
    input  r_data
  );

  modport slave (
    input  addr,
    input  w_data,
    input  w_en,
    output r_data
  );

endinterface

// File: rtl/trap_controller.sv
// Sequences trap entry and MRET through the single-port machine CSR file, sharing that
// port with pipeline CSR instructions; stalls the pipeline and issues one PC redirect.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] IRQ_CAUSE = IrqCauseMext
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                exc_req,
  input  logic [XLEN-1:0]     exc_cause,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic [XLEN-1:0]     commit_pc,
  input  logic                irq_ext,
  input  logic                mret_req,
  output logic                busy,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  trap_controller_if.slave    inst,
  trap_controller_if.master   csr
);

  trap_state_e state_q, state_d;

  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            is_irq_q, is_irq_d;
  logic            busy_q;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            shadow_mie_q, shadow_mie_d;
  logic            shadow_meie_q, shadow_meie_d;

  logic [XLEN-1:0] status_trap;
  logic [XLEN-1:0] status_mret;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] tvec_target;
  logic            irq_take;

  assign busy           = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign inst.r_data    = csr.r_data;

  assign irq_take = irq_ext & shadow_mie_q & shadow_meie_q;

  // Address depends on state only, so the combinational read never loops back into it.
  always_comb begin
    csr.addr = inst.addr;
    unique case (state_q)
      StIdle:                 csr.addr = inst.addr;
      StWEpc, StMEpc:         csr.addr = CsrMepc;
      StWCause:               csr.addr = CsrMcause;
      StWTval:                csr.addr = CsrMtval;
      StWStatus, StMStatus:   csr.addr = CsrMstatus;
      StRTvec:                csr.addr = CsrMtvec;
      default:                csr.addr = CsrMstatus;
    endcase
  end

  // Read-modify-write images of mstatus and the trap vector target.
  always_comb begin
    status_trap                            = csr.r_data;
    status_trap[MstatusMpie]               = csr.r_data[MstatusMie];
    status_trap[MstatusMie]                = 1'b0;
    status_trap[MstatusMppHi:MstatusMppLo] = 2'b11;

    status_mret              = csr.r_data;
    status_mret[MstatusMie]  = csr.r_data[MstatusMpie];
    status_mret[MstatusMpie] = 1'b1;

    tvec_base   = {csr.r_data[XLEN-1:2], 2'b00};
    tvec_target = tvec_base;
    if (is_irq_q && (csr.r_data[1:0] == TvecModeVectored)) begin
      tvec_target = tvec_base + {cause_q[XLEN-3:0], 2'b00};
    end
  end

  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    cause_d          = cause_q;
    tval_d           = tval_q;
    is_irq_d         = is_irq_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    shadow_mie_d     = shadow_mie_q;
    shadow_meie_d    = shadow_meie_q;
    csr.w_data       = inst.w_data;
    csr.w_en         = 1'b0;

    unique case (state_q)
      StIdle: begin
        csr.w_en = inst.w_en;
        if (inst.w_en && (inst.addr == CsrMstatus)) begin
          shadow_mie_d = inst.w_data[MstatusMie];
        end
        if (inst.w_en && (inst.addr == CsrMie)) begin
          shadow_meie_d = inst.w_data[MieMeie];
        end
        if (exc_req) begin
          state_d  = StWEpc;
          epc_d    = commit_pc;
          cause_d  = exc_cause;
          tval_d   = exc_tval;
          is_irq_d = 1'b0;
        end else if (mret_req) begin
          state_d = StMStatus;
        end else if (irq_take) begin
          state_d  = StWEpc;
          epc_d    = commit_pc;
          cause_d  = IRQ_CAUSE;
          tval_d   = '0;
          is_irq_d = 1'b1;
        end
      end
      StWEpc: begin
        csr.w_data = epc_q;
        csr.w_en   = 1'b1;
        state_d    = StWCause;
      end
      StWCause: begin
        csr.w_data = cause_q;
        csr.w_en   = 1'b1;
        state_d    = StWTval;
      end
      StWTval: begin
        csr.w_data = tval_q;
        csr.w_en   = 1'b1;
        state_d    = StWStatus;
      end
      StWStatus: begin
        csr.w_data   = status_trap;
        csr.w_en     = 1'b1;
        shadow_mie_d = 1'b0;
        state_d      = StRTvec;
      end
      StRTvec: begin
        csr.w_data       = '0;
        redirect_pc_d    = tvec_target;
        redirect_valid_d = 1'b1;
        state_d          = StIdle;
      end
      StMStatus: begin
        csr.w_data   = status_mret;
        csr.w_en     = 1'b1;
        shadow_mie_d = csr.r_data[MstatusMpie];
        state_d      = StMEpc;
      end
      StMEpc: begin
        csr.w_data       = '0;
        redirect_pc_d    = {csr.r_data[XLEN-1:2], 2'b00};
        redirect_valid_d = 1'b1;
        state_d          = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      epc_q            <= '0;
      cause_q          <= '0;
      tval_q           <= '0;
      is_irq_q         <= 1'b0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      shadow_mie_q     <= 1'b0;
      shadow_meie_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      epc_q            <= epc_d;
      cause_q          <= cause_d;
      tval_q           <= tval_d;
      is_irq_q         <= is_irq_d;
      busy_q           <= (state_d != StIdle);
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      shadow_mie_q     <= shadow_mie_d;
      shadow_meie_q    <= shadow_meie_d;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: a CSR-level reference model predicts each redirect
// and the resulting CSR contents; a monitor compares them when redirect_valid fires.
module tb_trap_controller;
  import trap_controller_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        exc_req, irq_ext, mret_req;
  logic [31:0] exc_cause, exc_tval, commit_pc;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  trap_controller_if inst_if ();
  trap_controller_if csr_if ();

  trap_controller dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .exc_req        (exc_req),
    .exc_cause      (exc_cause),
    .exc_tval       (exc_tval),
    .commit_pc      (commit_pc),
    .irq_ext        (irq_ext),
    .mret_req       (mret_req),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst_if),
    .csr            (csr_if)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural CSR register file on the controller's port.
  logic [31:0] rf [4096];
  always @(posedge clock) if (csr_if.w_en) rf[csr_if.addr] <= csr_if.w_data;
  assign csr_if.r_data = rf[csr_if.addr];

  // Reference model: architectural CSR values and expected redirects.
  logic [31:0] m_csr [4096];
  typedef struct {
    logic [31:0] pc;
    int unsigned cyc;
    logic [31:0] mepc, mcause, mtval, mstatus;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clock) begin
    if (rst_n && redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_redirect: got pc %h, expected none", redirect_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("redirect_pc", redirect_pc, e.pc);
        check("redirect_cycle", cyc, e.cyc);
        check("busy_at_redirect", {31'b0, busy}, 32'h0);
        check("mepc", rf[CsrMepc], e.mepc);
        check("mcause", rf[CsrMcause], e.mcause);
        check("mtval", rf[CsrMtval], e.mtval);
        check("mstatus", rf[CsrMstatus], e.mstatus);
      end
    end
  end

  function automatic void push_exp(logic [31:0] pc, int unsigned c);
    exp_t e;
    e.pc      = pc;
    e.cyc     = c;
    e.mepc    = m_csr[CsrMepc];
    e.mcause  = m_csr[CsrMcause];
    e.mtval   = m_csr[CsrMtval];
    e.mstatus = m_csr[CsrMstatus];
    exp_q.push_back(e);
  endfunction

  function automatic void model_trap(logic [31:0] cause, logic [31:0] tval, logic [31:0] pc,
                                     bit irq, int unsigned c0);
    logic [31:0] st, tv, tgt;
    m_csr[CsrMepc]   = pc;
    m_csr[CsrMcause] = cause;
    m_csr[CsrMtval]  = tval;
    st      = m_csr[CsrMstatus];
    st[7]   = st[3];
    st[3]   = 1'b0;
    st[12:11] = 2'b11;
    m_csr[CsrMstatus] = st;
    tv  = m_csr[CsrMtvec];
    tgt = tv & ~32'h3;
    if (irq && tv[1:0] == 2'b01) tgt = tgt + (cause & 32'h7FFF_FFFF) * 4;
    push_exp(tgt, c0 + 6);
  endfunction

  function automatic void model_mret(int unsigned c0);
    logic [31:0] st;
    st    = m_csr[CsrMstatus];
    st[3] = st[7];
    st[7] = 1'b1;
    m_csr[CsrMstatus] = st;
    push_exp(m_csr[CsrMepc] & ~32'h3, c0 + 3);
  endfunction

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    inst_if.addr   = addr;
    inst_if.w_data = data;
    inst_if.w_en   = 1'b1;
    m_csr[addr]    = data;
    @(posedge clock); #1;
    inst_if.w_en   = 1'b0;
  endtask

  task automatic csr_read_check(input logic [11:0] addr);
    inst_if.addr = addr;
    #1;
    check("pipe_read", inst_if.r_data, m_csr[addr]);
  endtask

  task automatic request(input bit exc, input bit mret, input bit irq, input logic [31:0] cause,
                         input logic [31:0] tval, input logic [31:0] pc, output bit acc);
    logic [31:0] st, ie;
    int unsigned c0;
    c0 = cyc;
    st = m_csr[CsrMstatus];
    ie = m_csr[CsrMie];
    exc_req = exc; mret_req = mret; irq_ext = irq;
    exc_cause = cause; exc_tval = tval; commit_pc = pc;
    acc = 1'b1;
    if (exc) model_trap(cause, tval, pc, 1'b0, c0);
    else if (mret) model_mret(c0);
    else if (irq && st[3] && ie[11]) model_trap(32'h8000_000B, 32'h0, pc, 1'b1, c0);
    else acc = 1'b0;
    @(posedge clock); #1;
    exc_req = 1'b0; mret_req = 1'b0; irq_ext = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL redirect_timeout: got no redirect, expected %0d pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check("busy_idle", {31'b0, busy}, 32'h0);
      check("no_redirect", {31'b0, redirect_valid}, 32'h0);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] om_cause, om_tval, om_status;
    rst_n = 1'b0;
    exc_req = 0; irq_ext = 0; mret_req = 0;
    exc_cause = 0; exc_tval = 0; commit_pc = 0;
    inst_if.addr = CsrMstatus; inst_if.w_data = 0; inst_if.w_en = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // 1: plain exception
    csr_write(CsrMstatus, 32'h0);
    csr_write(CsrMie, 32'h0);
    csr_write(CsrMepc, 32'h0);
    csr_write(CsrMcause, 32'h0);
    csr_write(CsrMtval, 32'h0);
    csr_write(CsrMtvec, 32'h200);
    csr_read_check(CsrMtvec);
    request(1, 0, 0, 32'h2, 32'hDEAD, 32'h100, acc);
    wait_done();

    // 2: vectored external interrupt
    csr_write(CsrMstatus, 32'h8);
    csr_write(CsrMie, 32'h800);
    csr_write(CsrMtvec, 32'h401);
    request(0, 0, 1, 32'h0, 32'h0, 32'h180, acc);
    wait_done();

    // 3: interrupt masked by mstatus.MIE
    csr_write(CsrMstatus, 32'h0);
    request(0, 0, 1, 32'h0, 32'h0, 32'h1C0, acc);
    check_idle(4);

    // 4: MRET
    csr_write(CsrMepc, 32'h344);
    csr_write(CsrMstatus, 32'h80);
    request(0, 1, 0, 32'h0, 32'h0, 32'h0, acc);
    wait_done();

    // 5: all three at once, plus a pipeline write while busy
    csr_write(CsrMie, 32'h800);
    csr_write(CsrMtvec, 32'h300);
    request(1, 1, 1, 32'h7, 32'h1234, 32'h500, acc);
    inst_if.addr = CsrMtvec; inst_if.w_data = 32'hFFFF_FFF0; inst_if.w_en = 1'b1;
    @(posedge clock); #1;
    inst_if.w_en = 1'b0;
    wait_done();
    csr_read_check(CsrMtvec);

    // 6: reset in the middle of trap entry
    om_cause = m_csr[CsrMcause]; om_tval = m_csr[CsrMtval]; om_status = m_csr[CsrMstatus];
    request(1, 0, 0, 32'h5, 32'h77, 32'h600, acc);
    @(posedge clock); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check("midrst_redirect_pc", redirect_pc, 32'h0);
    exp_q.delete();
    m_csr[CsrMcause] = om_cause; m_csr[CsrMtval] = om_tval; m_csr[CsrMstatus] = om_status;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    check("midrst_mepc", rf[CsrMepc], 32'h600);
    check("midrst_mcause", rf[CsrMcause], om_cause);
    csr_write(CsrMstatus, 32'h8);
    csr_write(CsrMie, 32'h800);
    request(1, 0, 0, 32'h3, 32'h99, 32'h700, acc);
    wait_done();

    // Randomized mix of CSR updates and requests
    for (int it = 0; it < 80; it++) begin
      int unsigned op;
      op = $urandom_range(0, 6);
      case (op)
        0: csr_write(CsrMstatus, $urandom & 32'h1888);
        1: csr_write(CsrMie, ($urandom_range(0, 1) != 0) ? 32'h800 : 32'h0);
        2: csr_write(CsrMtvec, $urandom);
        3: csr_write(CsrMepc, $urandom);
        default: begin
          request($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, acc);
          if (acc) wait_done();
          else check_idle(2);
        end
      endcase
    end

    csr_read_check(CsrMstatus);
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
